// File: rtl/muldiv_if.sv
// Request/response bundle between the core's execute stage and the
// iterative multiply/divide unit.
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            flush;
  logic [2:0]      funct3;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic [4:0]      rd_address_in;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_address_out;
  logic            write_enable;

  modport master (
    output start, flush, funct3, operand_a, operand_b, rd_address_in,
    input  busy, done, result, rd_address_out, write_enable
  );

  modport slave (
    input  start, flush, funct3, operand_a, operand_b, rd_address_in,
    output busy, done, result, rd_address_out, write_enable
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on one 2*XLEN accumulator, with a single-cycle fast
// path for divide-by-zero and signed overflow.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic     clock,
  input  logic     reset,
  muldiv_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};

  state_t            state;
  logic [2:0]        op;
  logic [2*XLEN-1:0] acc;      // MUL: {partial, multiplier}; DIV: {rem, dividend/quotient}
  logic [XLEN-1:0]   opnd;     // multiplicand or divisor magnitude
  logic [CNT_W-1:0]  cnt;
  logic              neg;
  logic [XLEN-1:0]   result_q;
  logic [4:0]        rd_q;
  logic              done_q;
  logic              we_q;

  // Capture-time decode: signedness, magnitudes, fast-path detection
  logic            a_sgn, b_sgn, sign_a, sign_b, neg_cap;
  logic [XLEN-1:0] a_mag, b_mag, fast_res;
  logic            is_div, div_zero, div_ovf, fast;

  always_comb begin
    a_sgn    = (bus.funct3 == 3'd1) || (bus.funct3 == 3'd2) ||
               (bus.funct3 == 3'd4) || (bus.funct3 == 3'd6);
    b_sgn    = (bus.funct3 == 3'd1) || (bus.funct3 == 3'd4) || (bus.funct3 == 3'd6);
    sign_a   = a_sgn & bus.operand_a[XLEN-1];
    sign_b   = b_sgn & bus.operand_b[XLEN-1];
    a_mag    = sign_a ? -bus.operand_a : bus.operand_a;
    b_mag    = sign_b ? -bus.operand_b : bus.operand_b;
    // REM takes the dividend's sign; everything else the product of signs
    neg_cap  = (bus.funct3 == 3'd6) ? sign_a : (sign_a ^ sign_b);
    is_div   = bus.funct3[2];
    div_zero = (bus.operand_b == '0);
    div_ovf  = !bus.funct3[0] && (bus.operand_a == MIN_NEG) && (bus.operand_b == ALL_ONE);
    fast     = is_div && (div_zero || div_ovf);
    if (bus.funct3[1]) fast_res = div_zero ? bus.operand_a : '0;
    else               fast_res = div_zero ? ALL_ONE : MIN_NEG;
  end

  // One iteration of each algorithm plus the sign-corrected final result
  logic [XLEN:0]     mul_sum, rem_sh, diff;
  logic [2*XLEN-1:0] mul_next, div_next, prod_fix;
  logic [XLEN-1:0]   mul_res, div_val, div_res;
  logic              last;

  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next = {mul_sum, acc[XLEN-1:1]};
    rem_sh   = acc[2*XLEN-1:XLEN-1];
    diff     = rem_sh - {1'b0, opnd};
    div_next = diff[XLEN] ? {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                          : {diff[XLEN-1:0],   acc[XLEN-2:0], 1'b1};
    prod_fix = neg ? -mul_next : mul_next;
    mul_res  = (op == 3'd0) ? mul_next[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    div_val  = op[1] ? div_next[2*XLEN-1:XLEN] : div_next[XLEN-1:0];
    div_res  = neg ? -div_val : div_val;
    last     = (cnt == CNT_W'(XLEN-1));
  end

  // Control FSM and datapath registers; flush overrides everything
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      op       <= '0;
      acc      <= '0;
      opnd     <= '0;
      cnt      <= '0;
      neg      <= 1'b0;
      result_q <= '0;
      rd_q     <= '0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      we_q   <= 1'b0;
      if (bus.flush) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: if (bus.start) begin
            op   <= bus.funct3;
            rd_q <= bus.rd_address_in;
            neg  <= neg_cap;
            cnt  <= '0;
            if (fast) begin
              result_q <= fast_res;
              done_q   <= 1'b1;
              we_q     <= (bus.rd_address_in != 5'd0);
              state    <= S_DONE;
            end else if (is_div) begin
              acc   <= {{XLEN{1'b0}}, a_mag};
              opnd  <= b_mag;
              state <= S_DIV;
            end else begin
              acc   <= {{XLEN{1'b0}}, b_mag};
              opnd  <= a_mag;
              state <= S_MUL;
            end
          end
          S_MUL: begin
            acc <= mul_next;
            cnt <= cnt + CNT_W'(1);
            if (last) begin
              result_q <= mul_res;
              done_q   <= 1'b1;
              we_q     <= (rd_q != 5'd0);
              state    <= S_DONE;
            end
          end
          S_DIV: begin
            acc <= div_next;
            cnt <= cnt + CNT_W'(1);
            if (last) begin
              result_q <= div_res;
              done_q   <= 1'b1;
              we_q     <= (rd_q != 5'd0);
              state    <= S_DONE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.busy           = (state != S_IDLE);
  assign bus.done           = done_q;
  assign bus.result         = result_q;
  assign bus.rd_address_out = rd_q;
  assign bus.write_enable   = we_q;
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit.
- Consumes the two operands read from the register file (rs1_data, rs2_data) and returns the result plus destination address and write strobe for the register-file write port.
- Radix-2 shift-add multiplier and restoring divider sharing one datapath. A fast path handles divide-by-zero and signed overflow.
- The core stalls on busy and writes back when done pulses.

Parameters:
- XLEN, 32, operand/result width (only 32 is verified).
- CNT_W, 6, iteration counter width; must hold the value XLEN.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- flush  input  1  synchronous abort of the current operation
- funct3  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- operand_a  input  XLEN  rs1 value
- operand_b  input  XLEN  rs2 value
- rd_address_in  input  5  destination register
- busy  output  1  operation in progress (not IDLE)
- done  output  1  one-cycle result-valid pulse
- result  output  XLEN  result; valid while done=1
- rd_address_out  output  5  captured destination; valid with done
- write_enable  output  1  equals done && rd_address_out != 0

Behaviour:
- Clock and reset:
  - reset is asynchronous, active-high; clock is clock.
  - On reset: state=IDLE; busy=0, done=0, write_enable=0; result=0, rd_address_out=0; counter=0; internal registers cleared.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - If start=1 and flush=0 at edge E0, capture funct3, operands and rd_address_in.
  - If the operation is DIV/DIVU/REM/REMU and (operand_b==0, or signed op with operand_a==0x80000000 and operand_b==0xFFFFFFFF): go to DONE with the fast-path result.
  - Otherwise the multiply ops go to MUL and the divide ops go to DIV, with counter=0.
- Operand conditioning:
  - Signed operands (MULH: both; MULHSU: a only; DIV/REM: both) are converted to magnitude at capture.
  - A negate flag is recorded: MUL-type = sign_a XOR sign_b; REM = sign_a; DIV = sign_a XOR sign_b.
- MUL:
  - Each cycle, if the multiplier LSB=1, add the multiplicand into the upper half of a 2*XLEN accumulator. Then shift right by 1 and increment the counter.
  - After XLEN iterations (counter==XLEN-1 at edge E32), go to DONE.
- DIV:
  - Each cycle, shift the {remainder, dividend} pair left by 1 and trial-subtract the divisor. If non-negative, keep the difference and set quotient bit 1.
  - After XLEN iterations, go to DONE.
- DONE:
  - Lasts exactly one cycle: done=1, busy=1, result applied with sign correction. Then go to IDLE.
  - Result selection:
    - MUL: low XLEN bits of the product.
    - MULH/MULHSU/MULHU: high XLEN bits of the (sign-corrected) product.
    - DIV/DIVU: quotient.
    - REM/REMU: remainder.
- Latency:
  - Normal operation: done is high in the cycle after E32 (33 cycles after start is accepted). A new start is accepted at the edge that ends DONE+1, i.e. the next cycle in IDLE.
  - Fast path: done is high in the cycle immediately after E0.
- Fast-path results:
  - Divide by zero: DIV/DIVU = 0xFFFFFFFF; REM/REMU = operand_a.
  - Signed overflow: DIV = 0x80000000; REM = 0.
- Concurrency and abort:
  - start while busy is ignored (no queueing).
  - flush=1 at any edge forces IDLE with done=0, and no write occurs. flush has priority over start and over the DONE pulse.
  - Reset mid-operation aborts immediately, with no done.
- Output validity:
  - result and rd_address_out hold their last value after done; only the done cycle is architecturally valid.
  - write_enable is never asserted for rd=0.
- Operand capture: inputs may change after the start edge; only captured values are used.

Test Plan:
- Reset → busy=0, done=0, write_enable=0, result=0. Assert reset mid-MUL at counter 10 → IDLE immediately, no done pulse.
- MUL a=7, b=6, rd=5 → done exactly 33 cycles after start edge, result=42, write_enable=1, rd_address_out=5. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- MULH a=-3 (0xFFFFFFFD), b=5 → 0xFFFFFFFF. MULHSU a=-1, b=0xFFFFFFFF → 0xFFFFFFFF. MUL of the same -3×5 → 0xFFFFFFF1.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2; each completes in 33 cycles.
- Fast path, each with done one cycle after start:
  - DIVU x/0 → 0xFFFFFFFF.
  - REM 0x1234/0 → 0x1234.
  - DIV 0x80000000/-1 → 0x80000000.
  - REM 0x80000000/-1 → 0.
- rd=0 → done=1 with write_enable=0. start pulsed while busy is ignored, and the first result is unchanged. flush at counter 20 → IDLE next cycle, no done; a start in the following cycle is accepted normally.
